stc_scheduler: RTL

- Dispatcher for a 4-lane sparse tensor core cluster (four spTensorCore lanes).
- Replaces the fixed free-running start rotation with a demand-driven scheduler.
- Grants the shared A/B/C/weight-index input bus to one idle lane at a time, and counts the operand beats for that lane.
- Sequences the lane's start and fetch_done pulses, and steers the shared result bus in dispatch (FIFO) order.

---
 rtl/stc_sched_pkg.sv | 39 +++
 rtl/stc_order_fifo.sv | 67 ++++++
 rtl/stc_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/stc_sched_pkg.sv
// Shared types and helpers for the stc_scheduler tensor-core dispatcher.
package stc_sched_pkg;

  localparam int unsigned MAX_CORES = 8;
  localparam int unsigned MAX_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FETCH = 2'd2
  } state_t;

  // One-hot decode of a lane index into a MAX_CORES-wide vector.
  function automatic logic [MAX_CORES-1:0] onehot(input logic [MAX_ID_W-1:0] idx);
    logic [MAX_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating-priority search: first set bit of mask at or after ptr, over n lanes.
  // Returns {found, index}.
  function automatic logic [MAX_ID_W:0] rr_pick(input logic [MAX_CORES-1:0] mask,
                                                input logic [MAX_ID_W-1:0]  ptr,
                                                input int unsigned          n);
    logic [MAX_ID_W:0] r;
    int unsigned       j;
    r = '0;
    j = 0;
    for (int unsigned k = 0; k < MAX_CORES; k++) begin
      if (k < n) begin
        j = (32'(ptr) + k) % n;
        if (!r[MAX_ID_W] && mask[j[MAX_ID_W-1:0]]) r = {1'b1, j[MAX_ID_W-1:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stc_order_fifo.sv
// Dispatch-order FIFO of lane IDs; head is entry 0, entries shift on pop.
module stc_order_fifo
  import stc_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head,
  output logic             empty,
  output logic             full,
  output logic [DEPTH-1:0] contains
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ID_W-1:0]  ent     [DEPTH];
  logic [ID_W-1:0]  ent_nxt [DEPTH];
  logic [CNT_W-1:0] count, count_nxt, wpos;
  logic             pop_ok, push_ok;

  // Next-entry computation: shift on pop, then write at the (possibly shifted) tail.
  always_comb begin
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    ent_nxt   = ent;
    count_nxt = count;
    if (pop_ok) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) ent_nxt[i] = ent[i+1];
    end
    wpos = pop_ok ? (count - 1'b1) : count;
    if (push_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wpos) ent_nxt[i] = push_id;
      end
    end
    if (push_ok && !pop_ok)      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok) count_nxt = count - 1'b1;
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      count <= '0;
    end else begin
      ent   <= ent_nxt;
      count <= count_nxt;
    end
  end

  // Status decode and membership mask of occupied entries.
  always_comb begin
    head     = ent[0];
    empty    = (count == '0);
    full     = (count == CNT_W'(DEPTH));
    contains = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) contains[ent[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/stc_scheduler.sv
// Demand-driven dispatcher for a cluster of sparse tensor-core lanes.
// Optional performance counters are enabled with `define STC_SCHED_PERF_EN.
module stc_scheduler
  import stc_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned FETCH_BEATS = 4,
  parameter int unsigned ID_W        = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_CORES-1:0] core_idle,
  input  logic [NUM_CORES-1:0] core_fetch,
  input  logic [NUM_CORES-1:0] core_wb,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] core_fetch_done,
  output logic [NUM_CORES-1:0] in_sel,
  output logic [NUM_CORES-1:0] out_sel,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 err_order
`ifdef STC_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_jobs,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_bubble
`endif
);

  function automatic logic [MAX_ID_W-1:0] pad_id(input logic [ID_W-1:0] id);
    logic [MAX_ID_W-1:0] v;
    v           = '0;
    v[ID_W-1:0] = id;
    return v;
  endfunction

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        lane, lane_nxt, ptr, pick_id, head;
  logic [7:0]             beats;
  logic [NUM_CORES-1:0]   wb_prev, contains, elig, rise, head_mask;
  logic [MAX_CORES-1:0]   elig_w, oh_pick, oh_lane, oh_lnxt, oh_head;
  logic [MAX_ID_W:0]      pick;
  logic                   found, last_beat, push, pop, empty, full, err_set;
  logic                   unused_bits;

  stc_order_fifo #(
    .DEPTH (NUM_CORES),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_id  (pick_id),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .contains (contains)
  );

  // Lane search, handshake, next state and result-side bookkeeping.
  always_comb begin
    elig                   = core_idle & ~contains;
    elig_w                 = '0;
    elig_w[NUM_CORES-1:0]  = elig;
    pick                   = rr_pick(elig_w, pad_id(ptr), NUM_CORES);
    found                  = pick[MAX_ID_W];
    pick_id                = pick[ID_W-1:0];
    // job_ready is gated by rst so every output is low while reset is held.
    job_ready              = rst && (state == IDLE) && job_valid && found && !full;
    in_ready               = (state == FETCH);
    last_beat              = in_ready && in_valid && (beats == 8'(FETCH_BEATS - 1));
    push                   = job_ready;
    state_nxt              = state;
    lane_nxt               = lane;
    case (state)
      IDLE:    if (job_ready) begin
                 state_nxt = ARM;
                 lane_nxt  = pick_id;
               end
      ARM:     if (core_fetch[lane]) state_nxt = FETCH;
      FETCH:   if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    oh_pick      = onehot(pad_id(pick_id));
    oh_lane      = onehot(pad_id(lane));
    oh_lnxt      = onehot(pad_id(lane_nxt));
    oh_head      = onehot(pad_id(head));
    head_mask    = empty ? '0 : oh_head[NUM_CORES-1:0];
    pop          = !empty && wb_prev[head] && !core_wb[head];
    rise         = core_wb & ~wb_prev;
    err_set      = |(rise & ~head_mask);
    result_valid = !empty && core_wb[head];
    unused_bits  = ^{pick, oh_pick, oh_lane, oh_lnxt, oh_head};
  end

  // Result mux select and busy decode straight from state/FIFO flops, no input path.
  always_comb begin
    out_sel = head_mask;
    busy    = (state != IDLE) || !empty;
  end

  // State register, beat counter, pointer and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      lane            <= '0;
      ptr             <= '0;
      beats           <= '0;
      wb_prev         <= '0;
      core_start      <= '0;
      core_fetch_done <= '0;
      in_sel          <= '0;
      err_order       <= 1'b0;
    end else begin
      state   <= state_nxt;
      lane    <= lane_nxt;
      wb_prev <= core_wb;
      if (last_beat) begin
        beats <= '0;
        ptr   <= (lane == ID_W'(NUM_CORES - 1)) ? '0 : lane + 1'b1;
      end else if (in_ready && in_valid) begin
        beats <= beats + 8'd1;
      end
      core_start      <= job_ready ? oh_pick[NUM_CORES-1:0] : '0;
      core_fetch_done <= last_beat ? oh_lane[NUM_CORES-1:0] : '0;
      in_sel          <= (state_nxt != IDLE) ? oh_lnxt[NUM_CORES-1:0] : '0;
      err_order       <= err_order | err_set;
    end
  end

`ifdef STC_SCHED_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_jobs   <= '0;
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (job_ready && perf_jobs != '1) perf_jobs <= perf_jobs + 32'd1;
      if (job_valid && !job_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      if ((state == FETCH) && !in_valid && perf_bubble != '1) perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule
